// File: rtl/d_jal_redirect.sv
// d_jal_redirect: decode-stage jal resolver and return-address stack.
//   Selects the oldest valid jal in the decode group, computes its word
//   target and, when fetch predicted something else, emits a registered
//   one-cycle redirect with a kill mask for younger lanes. Calls push
//   pc+1 onto a circular RAS that fetch pops when it predicts a return.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid, pc, imm,  per-lane decode group (lane 0 oldest)
//   jump_code, is_call
//   pc_predicted        fetch next-PC prediction for this group
//   stall, flush_in     decode hold, E-stage redirect (highest priority)
//   ras_pop             fetch predicted a return this cycle
//   redirect_valid/pc   registered redirect pulse and target
//   kill_mask           lanes younger than the resolved jal
//   ras_top, ras_empty  registered RAS top of stack / empty flag
//   mispredict_cnt      saturating redirect counter
module d_jal_redirect #(
  parameter int LANES     = 2,
  parameter int PC_W      = 13,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      in_valid,
  input  logic [LANES*PC_W-1:0] pc,
  input  logic [LANES*32-1:0]   imm,
  input  logic [LANES*2-1:0]    jump_code,
  input  logic [LANES-1:0]      is_call,
  input  logic [PC_W-1:0]       pc_predicted,
  input  logic                  stall,
  input  logic                  flush_in,
  input  logic                  ras_pop,
  output logic                  redirect_valid,
  output logic [PC_W-1:0]       redirect_pc,
  output logic [LANES-1:0]      kill_mask,
  output logic [PC_W-1:0]       ras_top,
  output logic                  ras_empty,
  output logic [CNT_W-1:0]      mispredict_cnt
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(RAS_DEPTH);

  logic                 shadow;
  logic                 accept;
  logic                 sel_found;
  logic                 blocked;
  logic [PC_W-1:0]      sel_pc;
  logic [PC_W-1:0]      sel_off;
  logic                 sel_call;
  logic [LANES-1:0]     kill_next;
  logic [PC_W-1:0]      target;
  logic                 mispredict;
  logic                 push;
  logic [PC_W-1:0]      push_val;

  logic [PC_W-1:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]     ras_ptr;
  logic [PTR_W:0]       ras_cnt;
  logic [PTR_W-1:0]     ptr_inc;
  logic [PTR_W-1:0]     ptr_dec;

  assign accept = !stall && !flush_in && !shadow;

  // Walk lanes oldest first. An earlier valid E-resolved jump blocks any
  // later jal; once a jal is found, every later lane lands in the kill mask.
  always_comb begin
    sel_found = 1'b0;
    blocked   = 1'b0;
    sel_pc    = '0;
    sel_off   = '0;
    sel_call  = 1'b0;
    kill_next = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sel_found) begin
        kill_next[i] = 1'b1;
      end else if (!blocked && in_valid[i]) begin
        if (jump_code[i*2 +: 2] == 2'b10) begin
          sel_found = 1'b1;
          sel_pc    = pc[i*PC_W +: PC_W];
          sel_off   = imm[i*32 + 2 +: PC_W];
          sel_call  = is_call[i];
        end else if (jump_code[i*2 +: 2] != 2'b00) begin
          blocked = 1'b1;
        end
      end
    end
  end

  assign target     = sel_pc + sel_off;
  assign mispredict = accept && sel_found && (target != pc_predicted);
  assign push       = accept && sel_found && sel_call;
  assign push_val   = sel_pc + PC_W'(1);
  assign ptr_inc    = ras_ptr + PTR_W'(1);
  assign ptr_dec    = ras_ptr - PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      kill_mask      <= '0;
      shadow         <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      // A mispredict implies accept, so flush and shadow both clear here.
      redirect_valid <= mispredict;
      shadow         <= mispredict;
      if (mispredict) begin
        redirect_pc <= target;
        kill_mask   <= kill_next;
        if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr   <= '0;
      ras_cnt   <= '0;
      ras_top   <= '0;
      ras_empty <= 1'b1;
    end else if (push && ras_pop && ras_cnt != '0) begin
      // Return leaves and call enters together: replace the top in place.
      ras_top <= push_val;
    end else if (push) begin
      ras_ptr   <= ptr_inc;
      ras_top   <= push_val;
      ras_empty <= 1'b0;
      if (ras_cnt != CNT_FULL) ras_cnt <= ras_cnt + (PTR_W+1)'(1);
    end else if (ras_pop && ras_cnt != '0) begin
      ras_ptr <= ptr_dec;
      ras_cnt <= ras_cnt - (PTR_W+1)'(1);
      if (ras_cnt == (PTR_W+1)'(1)) begin
        ras_top   <= '0;
        ras_empty <= 1'b1;
      end else begin
        ras_top <= ras_mem[ptr_dec];
      end
    end
  end

  // Storage carries no reset; entries are only read below a valid count.
  always_ff @(posedge clk) begin
    if (push && ras_pop && ras_cnt != '0) ras_mem[ras_ptr] <= push_val;
    else if (push)                        ras_mem[ptr_inc] <= push_val;
  end

endmodule
